// File: rtl/asp_link_controller.sv
// asp_link_controller: arbitrates host transmits and inbound frames, tracks one tagged
// transmission, retransmits on ack timeout and drives the output stage with op pulses.
module asp_link_controller #(
    parameter int data_size      = 32,
    parameter int tag_size       = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          host_tx_valid,
    input  logic [data_size-1:0]          host_tx_data,
    output logic                          host_tx_ready,
    input  logic                          net_rx_valid,
    input  logic                          net_rx_is_ack,
    input  logic [data_size+tag_size-1:0] net_rx_frame,
    input  logic                          net_rx_parity_error,
    output logic [1:0]                    op_out,
    output logic [data_size-1:0]          tx_data_out,
    output logic [tag_size-1:0]           tx_tag_out,
    output logic [data_size+tag_size-1:0] tx_data_plus_tag_out,
    output logic [data_size+tag_size-1:0] ndt_out,
    output logic                          tag_match_out,
    output logic [data_size-1:0]          rx_data_out,
    output logic                          soft_error_out,
    output logic                          tx_fail_out,
    output logic [1:0]                    retry_count_out,
    output logic                          busy_out
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 2);
    localparam logic [1:0] NOP = 2'b00, TXE = 2'b01, RXA = 2'b10, RXD = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, RETRY} state_t;

    state_t              state, state_nxt;
    logic [TW-1:0]       timer;
    logic [RW-1:0]       retries;
    logic [tag_size-1:0] tag_cnt;
    logic [1:0]          op_nxt;
    logic                is_data, is_perr, ack_match, accept, timeout, can_retry, retry_go, fail;

    assign is_data   = net_rx_valid & ~net_rx_parity_error & ~net_rx_is_ack;
    assign is_perr   = net_rx_valid & net_rx_parity_error;
    assign ack_match = net_rx_valid & ~net_rx_parity_error & net_rx_is_ack & (state != IDLE)
                     & (net_rx_frame[tag_size-1:0] == tx_tag_out);
    assign accept    = host_tx_valid & host_tx_ready;
    assign timeout   = (state == WAIT_ACK) & (timer == TW'(TIMEOUT_CYCLES - 1)) & ~ack_match;
    assign can_retry = int'(retries) < MAX_RETRIES;
    // Any non-ack inbound frame holds the retransmission back a cycle; a matching ack cancels it.
    assign retry_go  = (state == RETRY) & ~ack_match & ~is_data & ~is_perr;
    assign fail      = timeout & ~can_retry;

    assign host_tx_ready        = ~reset & (state == IDLE) & ~net_rx_valid;
    assign tx_data_plus_tag_out = {tx_data_out, tx_tag_out};
    assign busy_out             = state != IDLE;
    assign retry_count_out      = (int'(retries) > 3) ? 2'd3 : 2'(retries);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = ack_match ? IDLE :
                    accept    ? WAIT_ACK :
                    timeout   ? (can_retry ? RETRY : IDLE) :
                    retry_go  ? WAIT_ACK : state;
    end

    always_comb begin
        op_nxt = is_data ? RXD : ack_match ? RXA : (accept | retry_go) ? TXE : NOP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer          <= '0;
            retries        <= '0;
            tag_cnt        <= '0;
            op_out         <= NOP;
            tag_match_out  <= 1'b0;
            soft_error_out <= 1'b0;
            tx_fail_out    <= 1'b0;
            tx_data_out    <= '0;
            tx_tag_out     <= '0;
            ndt_out        <= '0;
            rx_data_out    <= '0;
        end else begin
            op_out         <= op_nxt;
            tag_match_out  <= ack_match;
            soft_error_out <= is_perr;
            tx_fail_out    <= fail;
            timer          <= (state == WAIT_ACK && state_nxt == WAIT_ACK) ? timer + TW'(1) : '0;
            if (ack_match | fail | accept) retries <= '0;
            else if (retry_go) retries <= retries + RW'(1);
            if (ack_match | fail) tag_cnt <= tag_cnt + tag_size'(1);
            if (is_data) rx_data_out <= net_rx_frame[data_size+tag_size-1:tag_size];
            if (accept) begin
                tx_data_out <= host_tx_data;
                tx_tag_out  <= tag_cnt;
                ndt_out     <= {host_tx_data, tag_cnt};
            end
        end
    end
endmodule

// File: tb/tb_asp_link_controller.sv
// tb_asp_link_controller: directed plus randomized checks of asp_link_controller against a
// transaction-level reference model (short timeout so retries and failures are frequent).
module tb_asp_link_controller;
    localparam int TMO = 4, MAXR = 2;
    localparam logic [1:0] NOP = 2'b00, TXE = 2'b01, RXA = 2'b10, RXD = 2'b11;

    logic        clk = 1'b0, reset;
    logic        host_tx_valid, host_tx_ready, net_rx_valid, net_rx_is_ack, net_rx_parity_error;
    logic [31:0] host_tx_data, tx_data_out, rx_data_out;
    logic [39:0] net_rx_frame, tx_data_plus_tag_out, ndt_out;
    logic [7:0]  tx_tag_out;
    logic [1:0]  op_out, retry_count_out;
    logic        tag_match_out, soft_error_out, tx_fail_out, busy_out;

    int checks = 0, errors = 0;

    // reference model: an outstanding transmission, how long it has waited, and its retries
    bit          m_busy, m_pending;
    int          m_wait, m_retries;
    logic [7:0]  m_next_tag, m_tag;
    logic [31:0] m_data, m_rx;
    logic [1:0]  e_op;
    bit          e_match, e_soft, e_fail;

    asp_link_controller #(.data_size(32), .tag_size(8), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)) dut (
        .clk(clk), .reset(reset),
        .host_tx_valid(host_tx_valid), .host_tx_data(host_tx_data), .host_tx_ready(host_tx_ready),
        .net_rx_valid(net_rx_valid), .net_rx_is_ack(net_rx_is_ack), .net_rx_frame(net_rx_frame),
        .net_rx_parity_error(net_rx_parity_error),
        .op_out(op_out), .tx_data_out(tx_data_out), .tx_tag_out(tx_tag_out),
        .tx_data_plus_tag_out(tx_data_plus_tag_out), .ndt_out(ndt_out), .tag_match_out(tag_match_out),
        .rx_data_out(rx_data_out), .soft_error_out(soft_error_out), .tx_fail_out(tx_fail_out),
        .retry_count_out(retry_count_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit hv, input logic [31:0] hd, input bit nv,
                         input bit ack, input bit pe, input logic [39:0] fr);
        bit dat, match;
        if (r) begin
            m_busy = 0; m_pending = 0; m_wait = 0; m_retries = 0; m_next_tag = 0; m_tag = 0;
            m_data = 0; m_rx = 0; e_op = NOP; e_match = 0; e_soft = 0; e_fail = 0;
            return;
        end
        dat = nv && !pe && !ack;
        match = nv && !pe && ack && m_busy && fr[7:0] == m_tag;
        e_op = NOP; e_match = 0; e_soft = nv && pe; e_fail = 0;
        if (dat) begin e_op = RXD; m_rx = fr[39:8]; end
        if (match) begin
            e_op = RXA; e_match = 1; m_busy = 0; m_pending = 0; m_retries = 0; m_next_tag++;
        end else if (!m_busy) begin
            if (hv && !nv) begin
                e_op = TXE; m_data = hd; m_tag = m_next_tag; m_busy = 1; m_wait = 0;
            end
        end else if (m_pending) begin
            if (!dat && !(nv && pe)) begin
                e_op = TXE; m_pending = 0; m_retries++; m_wait = 0;
            end
        end else begin
            m_wait++;
            if (m_wait == TMO) begin
                if (m_retries < MAXR) m_pending = 1;
                else begin e_fail = 1; m_busy = 0; m_retries = 0; m_next_tag++; end
            end
        end
    endtask

    task automatic step(input bit r, input bit hv, input logic [31:0] hd, input bit nv,
                        input bit ack, input bit pe, input logic [39:0] fr);
        reset = r; host_tx_valid = hv; host_tx_data = hd; net_rx_valid = nv;
        net_rx_is_ack = ack; net_rx_parity_error = pe; net_rx_frame = fr;
        #1;
        chk("host_tx_ready", host_tx_ready, !r && !m_busy && !nv);
        model(r, hv, hd, nv, ack, pe, fr);
        @(posedge clk); #1;
        chk("op", op_out, e_op);
        chk("tag_match", tag_match_out, e_match);
        chk("soft_error", soft_error_out, e_soft);
        chk("tx_fail", tx_fail_out, e_fail);
        chk("rx_data", rx_data_out, m_rx);
        chk("tx_data", tx_data_out, m_data);
        chk("tx_tag", tx_tag_out, m_tag);
        chk("tx_data_plus_tag", tx_data_plus_tag_out, {m_data, m_tag});
        chk("ndt", ndt_out, {m_data, m_tag});
        chk("retry_count", retry_count_out, (m_retries > 3) ? 3 : m_retries);
        chk("busy", busy_out, m_busy);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send(input logic [31:0] d);
        step(0, 1, d, 0, 0, 0, 0);
    endtask

    task automatic ack_tag(input logic [7:0] t);
        step(0, 0, 0, 1, 1, 0, {32'h0, t});
    endtask

    initial begin
        #2;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h5, 0, 0, 0, 0);
        chk("reset_op", op_out, NOP);
        chk("reset_busy", busy_out, 0);
        // basic transmit and matching ack
        send(32'hDEADBEEF);
        chk("first_op", op_out, TXE);
        chk("first_ndt", ndt_out, 40'hDEADBEEF00);
        chk("first_busy", busy_out, 1);
        idle();
        ack_tag(8'h00);
        chk("ack_op", op_out, RXA);
        chk("ack_match", tag_match_out, 1);
        chk("ack_idle", busy_out, 0);
        send(32'h11111111);
        chk("second_tag", tx_tag_out, 8'h01);
        ack_tag(8'h01);
        // no ack: two retransmissions then failure
        send(32'hAAAA5555);
        chk("retx_first", op_out, TXE);
        for (int k = 1; k <= 14; k++) begin
            idle();
            if (k == 5 || k == 10) chk("retx_op", op_out, TXE);
            if (k == 5 || k == 10) chk("retx_tag", tx_tag_out, 8'h02);
            if (k == 13) chk("retx_count", retry_count_out, 2);
            if (k == 14) chk("retx_fail", tx_fail_out, 1);
        end
        idle();
        chk("fail_pulse_end", tx_fail_out, 0);
        send(32'h33333333);
        chk("tag_after_fail", tx_tag_out, 8'h03);
        ack_tag(8'h03);
        // mismatched ack ignored
        send(32'h44444444);
        ack_tag(8'h05);
        chk("mismatch_op", op_out, NOP);
        chk("mismatch_busy", busy_out, 1);
        ack_tag(8'h04);
        chk("late_match", tag_match_out, 1);
        // inbound data frame beats host transmit
        step(0, 1, 32'h55555555, 1, 0, 0, {32'h12345678, 8'h99});
        chk("rxd_op", op_out, RXD);
        chk("rxd_data", rx_data_out, 32'h12345678);
        send(32'h55555555);
        chk("deferred_txe", op_out, TXE);
        ack_tag(8'h05);
        // parity error frame
        step(0, 0, 0, 1, 0, 1, {32'hCAFEF00D, 8'h00});
        chk("perr_soft", soft_error_out, 1);
        chk("perr_op", op_out, NOP);
        idle();
        chk("perr_pulse_end", soft_error_out, 0);
        // matching ack in the timeout cycle wins
        send(32'h66666666);
        idle(); idle(); idle();
        ack_tag(8'h06);
        chk("timeout_ack_op", op_out, RXA);
        idle();
        chk("timeout_no_retx", op_out, NOP);
        chk("timeout_idle", busy_out, 0);
        // reset while waiting abandons the transmission silently
        send(32'h77777777);
        idle();
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_ndt", ndt_out, 0);
        for (int k = 0; k < 16; k++) idle();
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit r, hv, nv;
            int kind;
            logic [7:0] t;
            r = $urandom_range(0, 199) == 0;
            hv = $urandom_range(0, 1) == 1;
            nv = $urandom_range(0, 3) == 0;
            kind = $urandom_range(0, 3);
            if (m_pending && kind >= 2) kind = 0;
            t = (kind == 1) ? m_tag : 8'($urandom);
            step(r, hv, $urandom, nv, kind == 1 || kind == 2, kind == 3, {32'($urandom), t});
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/asp_link_controller.md
Name: asp_link_controller

Overview:
- Sequencing controller for the ASP output stage.
- Arbitrates between host transmit requests and inbound network frames, and assigns transmit tags.
- Tracks the single outstanding tagged transmission, matches returning acks against it, and retransmits on ack timeout.
- Drives the output stage's opcode, tx data/tag, tag-match, rx data and network-data-tag inputs with one-cycle operation pulses.

Parameters:
data_size, 32, payload width in bits
tag_size, 8, tag width in bits
TIMEOUT_CYCLES, 64, cycles in WAIT_ACK before retransmit (>=2)
MAX_RETRIES, 3, retransmissions before a transmission is declared failed (>=0)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
host_tx_valid  in  1  host has a payload to transmit
host_tx_data  in  data_size  host payload
host_tx_ready  out  1  combinational; = ~reset & (state==IDLE) & ~net_rx_valid; transfer on valid&ready
net_rx_valid  in  1  inbound frame present; always consumed in the same cycle
net_rx_is_ack  in  1  frame is an ack (tag in low tag_size bits)
net_rx_frame  in  data_size+tag_size  {payload, tag}
net_rx_parity_error  in  1  upstream parity check failed for this frame
op_out  out  2  00 NOP, 01 TXE, 10 RXA, 11 RXD; registered, one-cycle pulses
tx_data_out  out  data_size  payload of outstanding transmission
tx_tag_out  out  tag_size  tag of outstanding transmission
tx_data_plus_tag_out  out  data_size+tag_size  {tx_data_out, tx_tag_out}
ndt_out  out  data_size+tag_size  frame to send on TXE
tag_match_out  out  1  pulse with RXA when ack tag matched
rx_data_out  out  data_size  received payload, valid with RXD
soft_error_out  out  1  one-cycle pulse: inbound frame dropped for parity
tx_fail_out  out  1  one-cycle pulse: retries exhausted
retry_count_out  out  2  retries used on current transmission (saturating display)
busy_out  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, tag counter 0, timer 0, retry count 0. Reset mid-WAIT_ACK abandons the transmission with no tx_fail pulse.
- All registered outputs update 1 cycle after the deciding input cycle. Data outputs hold their value between pulses; only op_out, tag_match_out, soft_error_out and tx_fail_out return to 0.
- Inbound frame, any state; inbound frames take priority over host_tx:
  - parity_error=1: drop; soft_error_out=1; op NOP.
  - Data frame (is_ack=0): op RXD; rx_data_out=payload.
  - Ack in WAIT_ACK/RETRY with tag==tx_tag_out: op RXA, tag_match_out=1; tag counter +1 (wraps 2^tag_size-1 -> 0); state IDLE; timer and retries cleared.
  - Ack in any other case (IDLE or mismatched tag): dropped; op NOP.
- IDLE, no inbound frame, host_tx_valid=1: accept the payload.
  - tx_data_out=payload; tx_tag_out=tag counter; ndt_out={payload,tag}; op TXE.
  - State WAIT_ACK; timer=0.
- WAIT_ACK:
  - Timer increments each cycle.
  - At timer==TIMEOUT_CYCLES-1 with no matching ack that cycle: if retries<MAX_RETRIES, go to RETRY; otherwise tx_fail_out=1, tag counter +1, state IDLE.
  - A matching ack in the timeout cycle wins: no retry, no fail.
- RETRY (1 cycle): op TXE with the same ndt_out and tag; retries +1; timer=0; state WAIT_ACK.
  - If a matching ack arrives in this cycle, the ack is handled, the retransmission is cancelled and state goes to IDLE.
  - If a data frame arrives in this cycle, RXD takes op_out and TXE is deferred one cycle (stay in RETRY).
- At most one op per cycle. Exactly one outstanding transmission; host_tx_ready=0 whenever busy.

Test Plan:
- Reset, then host_tx_valid with data 0xDEADBEEF -> next cycle op TXE, ndt_out=0xDEADBEEF_00, busy_out=1; ack tag 0x00 -> op RXA, tag_match_out=1, IDLE; next transmission uses tag 0x01.
- TIMEOUT_CYCLES=4, MAX_RETRIES=2, no ack -> TXE at t, t+5, t+10 (same tag); tx_fail_out pulse at t+14; retry_count_out=2 before fail; tag counter advances.
- WAIT_ACK with ack tag 0x05 while outstanding tag is 0x04 -> no op, still WAIT_ACK; then ack 0x04 -> RXA with match.
- net_rx_valid data frame 0x12345678 and host_tx_valid in the same IDLE cycle -> RXD, rx_data_out=0x12345678, host_tx_ready=0; TXE follows 1 cycle later.
- net_rx_valid with parity error -> soft_error_out 1-cycle pulse, op NOP, state unchanged.
- Matching ack coincident with the timeout cycle -> RXA, no retransmit; reset asserted during WAIT_ACK -> all outputs 0, no tx_fail pulse.
